io_dev_ctrl: RTL and testbench
==============================

IO_DEV_CTRL -- requirements
Module: io_dev_ctrl

Interface
REQ-001 Parameter: SCAN_DIV, 50000, clock cycles per digit in the display scan (minimum 2).
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: dv_addr  input  12  device register offset from base 0xFFFFF000.
REQ-005 Port: dv_wr_data  input  32  write data from the IO bus.
REQ-006 Port: dv_wr_e  input  1  write enable from the IO bus; one write per asserted cycle.
REQ-007 Port: dv_rd_data  output  32  read data returned to the IO bus.
REQ-008 Port: sw  input  24  raw board switches, asynchronous to clk.
REQ-009 Port: btn  input  5  raw board buttons, asynchronous to clk.
REQ-010 Port: led  output  24  board LEDs, active high.
REQ-011 Port: dig_an  output  8  digit enables, active low; bit n selects digit n.
REQ-012 Port: dig_seg  output  8  segments, active low; bit0 = a through bit6 = g, bit7 = dp.

Function
REQ-013 The register map SHALL be: 0x000 DISP (R/W, 32 bit), 0x020 TIMER (R/W, 32 bit), 0x060 LED (R/W, bits 23:0), 0x070 SW (RO, bits 23:0), 0x078 BTN (RO, bits 4:0).
REQ-014 Reads SHALL be combinational on dv_addr, with no clock latency, because the bus muxes dv_rd_data in the same cycle.
REQ-015 Reads of unmapped offsets SHALL return 0, and unused upper bits of mapped registers SHALL read 0.
REQ-016 A write SHALL take effect at the rising edge where dv_wr_e=1 and SHALL be visible on a read in the following cycle.
REQ-017 Writes to SW, BTN, or unmapped offsets SHALL be ignored, with no state change.
REQ-018 The led output SHALL equal the LED register bits 23:0 directly.
REQ-019 sw and btn SHALL each pass through a 2-flop synchronizer, so a read reflects a pin change exactly 2 clock edges later.
REQ-020 TIMER SHALL increment by 1 every cycle and wrap from 0xFFFFFFFF to 0x00000000.
REQ-021 On a TIMER write, the written value SHALL be loaded and SHALL NOT be incremented in that cycle; the write takes priority over the increment.
REQ-022 The display scan SHALL use a divider counter that counts 0..SCAN_DIV-1.
REQ-023 When the divider reaches SCAN_DIV-1, it SHALL wrap to 0 and the 3-bit digit index SHALL advance, wrapping from 7 to 0.
REQ-024 dig_an SHALL be all ones except bit[index], which SHALL be 0.
REQ-025 dig_seg SHALL be the hex encoding of DISP[4*index+3 : 4*index], with dp off (bit7=1).
REQ-026 dig_an and dig_seg SHALL be registered so they change together, with no mismatched-digit glitch.
REQ-027 The hex encoding SHALL be: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
REQ-028 A DISP write SHALL be reflected on the currently lit digit at the next scan register update; the scan phase SHALL NOT be reset by the write.

Reset
REQ-029 While rst_n=0, DISP, LED, and TIMER SHALL be 0, the synchronizers SHALL be 0, and the divider and digit index SHALL be 0.
REQ-030 While rst_n=0, led SHALL be 0, dig_an SHALL be 8'hFF (all digits dark), and dig_seg SHALL be 8'hFF.
REQ-031 Reset assertion SHALL act immediately, including mid-scan or mid-write; an in-flight write SHALL be discarded.
REQ-032 After deassertion, TIMER SHALL count from 0 and digit 0 SHALL be lit first, at the first scan register update.

Verification
REQ-033 Scenario (SCAN_DIV=4): write DISP=0x89ABCDEF, then let the scan run. Required: digit 0 shows seg 8E on an FE, digit 1 shows seg 86 on an FD, digit 7 shows seg 80 on an 7F. Each digit SHALL hold for 4 cycles, and index 7 SHALL wrap back to 0.
REQ-034 Scenario: write LED=0xFFABCDEF. Required: led=0xABCDEF next cycle, and a read of 0x060 returns 0x00ABCDEF.
REQ-035 Scenario: write TIMER=0xFFFFFFFE. Required: reads in the following cycles return 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-036 Scenario: set sw=0x123456 and btn=5'b10001. Required: reads of 0x070 and 0x078 return 0x00123456 and 0x00000011 from the 2nd edge onward, and a write to 0x070 leaves both unchanged.
REQ-037 Scenario: assert rst_n=0 mid-scan at digit 5 with DISP nonzero. Required: dig_an=FF and led=0 immediately; after release, DISP reads 0 and digit 0 shows C0.
REQ-038 Scenario: read offset 0x044. Required: 0x00000000.

Source files
------------

// File: rtl/io_dev_ctrl.sv
// Memory-mapped IO device block: hex display scanner, free-running timer, LEDs,
// and synchronized switch/button inputs, all behind a 12-bit register offset.
module io_dev_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] dv_addr,
    input  logic [31:0] dv_wr_data,
    input  logic        dv_wr_e,
    output logic [31:0] dv_rd_data,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [7:0]  dig_an,
    output logic [7:0]  dig_seg
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    localparam logic [11:0] ADDR_DISP  = 12'h000;
    localparam logic [11:0] ADDR_TIMER = 12'h020;
    localparam logic [11:0] ADDR_LED   = 12'h060;
    localparam logic [11:0] ADDR_SW    = 12'h070;
    localparam logic [11:0] ADDR_BTN   = 12'h078;

    logic [31:0]      disp_q,  disp_d;
    logic [31:0]      timer_q, timer_d;
    logic [23:0]      led_q,   led_d;
    logic [23:0]      sw_s1_q, sw_s2_q;
    logic [4:0]       btn_s1_q, btn_s2_q;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [2:0]       idx_q,   idx_d;
    logic [7:0]       an_q,    an_d;
    logic [7:0]       seg_q,   seg_d;

    // Active-low seven-segment pattern, dp off.
    function automatic logic [7:0] hex7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_comb begin
        disp_d  = disp_q;
        led_d   = led_q;
        timer_d = timer_q + 32'd1;
        if (dv_wr_e) begin
            case (dv_addr)
                ADDR_DISP:  disp_d  = dv_wr_data;
                ADDR_TIMER: timer_d = dv_wr_data;
                ADDR_LED:   led_d   = dv_wr_data[23:0];
                default:    ;
            endcase
        end
    end

    // Scan divider and digit index; the anode/segment pair is registered as one
    // so both always describe the same digit.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end
        an_d  = ~(8'b0000_0001 << idx_q);
        seg_d = hex7(disp_q[{idx_q, 2'b00} +: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q   <= '0;
            timer_q  <= '0;
            led_q    <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            div_q    <= '0;
            idx_q    <= '0;
            an_q     <= 8'hFF;
            seg_q    <= 8'hFF;
        end else begin
            disp_q   <= disp_d;
            timer_q  <= timer_d;
            led_q    <= led_d;
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            div_q    <= div_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    always_comb begin
        case (dv_addr)
            ADDR_DISP:  dv_rd_data = disp_q;
            ADDR_TIMER: dv_rd_data = timer_q;
            ADDR_LED:   dv_rd_data = {8'h00, led_q};
            ADDR_SW:    dv_rd_data = {8'h00, sw_s2_q};
            ADDR_BTN:   dv_rd_data = {27'h0, btn_s2_q};
            default:    dv_rd_data = '0;
        endcase
    end

    assign led     = led_q;
    assign dig_an  = an_q;
    assign dig_seg = seg_q;

endmodule

// File: tb/tb_io_dev_ctrl.sv
// Directed bench for io_dev_ctrl with SCAN_DIV=4: a register-access vector
// table plus hand-written timer, synchronizer, scan and reset sequences.
module tb_io_dev_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] dv_addr;
    logic [31:0] dv_wr_data;
    logic        dv_wr_e;
    logic [31:0] dv_rd_data;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  dig_an;
    logic [7:0]  dig_seg;

    int n_cmp  = 0;
    int n_fail = 0;

    io_dev_ctrl #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dv_addr    (dv_addr),
        .dv_wr_data (dv_wr_data),
        .dv_wr_e    (dv_wr_e),
        .dv_rd_data (dv_rd_data),
        .sw         (sw),
        .btn        (btn),
        .led        (led),
        .dig_an     (dig_an),
        .dig_seg    (dig_seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [23:0] exp_led;
    } vec_t;

    vec_t vecs[12];
    logic [7:0] seg_exp[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        dv_addr = a;
        #1;
        check(name, dv_rd_data, exp);
    endtask

    initial begin
        int found;
        logic [7:0] prev_an;

        vecs[0]  = '{12'h060, 1'b1, 32'hFFABCDEF, 32'h00000000, 24'h000000};
        vecs[1]  = '{12'h060, 1'b0, 32'h0,        32'h00ABCDEF, 24'hABCDEF};
        vecs[2]  = '{12'h044, 1'b0, 32'h0,        32'h00000000, 24'hABCDEF};
        vecs[3]  = '{12'h044, 1'b1, 32'hDEADBEEF, 32'h00000000, 24'hABCDEF};
        vecs[4]  = '{12'h044, 1'b0, 32'h0,        32'h00000000, 24'hABCDEF};
        vecs[5]  = '{12'h000, 1'b1, 32'h12345678, 32'h00000000, 24'hABCDEF};
        vecs[6]  = '{12'h000, 1'b0, 32'h0,        32'h12345678, 24'hABCDEF};
        vecs[7]  = '{12'h060, 1'b1, 32'h00000001, 32'h00ABCDEF, 24'hABCDEF};
        vecs[8]  = '{12'h060, 1'b0, 32'h0,        32'h00000001, 24'h000001};
        vecs[9]  = '{12'h004, 1'b0, 32'h0,        32'h00000000, 24'h000001};
        vecs[10] = '{12'h070, 1'b0, 32'h0,        32'h00000000, 24'h000001};
        vecs[11] = '{12'h0FC, 1'b0, 32'h0,        32'h00000000, 24'h000001};

        // DISP=0x89ABCDEF, digit 0..7 = F,E,D,C,B,A,9,8
        seg_exp = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};

        rst_n = 1'b0; dv_addr = '0; dv_wr_data = '0; dv_wr_e = 1'b0; sw = '0; btn = '0;
        repeat (3) step();

        check("rst_led", {8'h0, led}, 32'h0);
        check("rst_an", {24'h0, dig_an}, 32'hFF);
        check("rst_seg", {24'h0, dig_seg}, 32'hFF);
        rd_check("rst_disp", 12'h000, 32'h0);
        rd_check("rst_timer", 12'h020, 32'h0);
        rd_check("rst_led_reg", 12'h060, 32'h0);

        rst_n = 1'b1;
        step();
        rd_check("timer_from_0", 12'h020, 32'h1);
        check("first_an", {24'h0, dig_an}, 32'hFE);
        check("first_seg", {24'h0, dig_seg}, 32'hC0);

        for (int i = 0; i < 12; i++) begin
            dv_addr    = vecs[i].addr;
            dv_wr_e    = vecs[i].wr;
            dv_wr_data = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rd", i), dv_rd_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_led", i), {8'h0, led}, {8'h0, vecs[i].exp_led});
            step();
        end
        dv_wr_e = 1'b0;

        // Timer load has priority over increment, then wraps.
        dv_addr = 12'h020; dv_wr_data = 32'hFFFFFFFE; dv_wr_e = 1'b1;
        step();
        dv_wr_e = 1'b0;
        rd_check("timer_load", 12'h020, 32'hFFFFFFFE);
        step();
        rd_check("timer_max", 12'h020, 32'hFFFFFFFF);
        step();
        rd_check("timer_wrap", 12'h020, 32'h00000000);

        // Synchronizer latency.
        sw = 24'h123456; btn = 5'b10001;
        rd_check("sw_edge0", 12'h070, 32'h0);
        step();
        rd_check("sw_edge1", 12'h070, 32'h0);
        rd_check("btn_edge1", 12'h078, 32'h0);
        step();
        rd_check("sw_edge2", 12'h070, 32'h00123456);
        rd_check("btn_edge2", 12'h078, 32'h00000011);
        dv_addr = 12'h070; dv_wr_data = 32'hFFFFFFFF; dv_wr_e = 1'b1;
        step();
        dv_wr_e = 1'b0;
        dv_addr = 12'h078; dv_wr_data = 32'hFFFFFFFF; dv_wr_e = 1'b1;
        step();
        dv_wr_e = 1'b0;
        rd_check("sw_ro", 12'h070, 32'h00123456);
        rd_check("btn_ro", 12'h078, 32'h00000011);

        // Scan: write DISP, then lock onto the transition into digit 0.
        dv_addr = 12'h000; dv_wr_data = 32'h89ABCDEF; dv_wr_e = 1'b1;
        step();
        dv_wr_e = 1'b0;
        found = 0;
        prev_an = dig_an;
        for (int c = 0; c < 100 && found == 0; c++) begin
            step();
            if (dig_an == 8'hFE && prev_an != 8'hFE) found = 1;
            prev_an = dig_an;
        end
        check("scan_sync_found", found, 1);
        if (found == 1) begin
            for (int k = 0; k < 40; k++) begin
                int d;
                d = (k / 4) % 8;
                check($sformatf("scan_an_k%0d", k), {24'h0, dig_an}, {24'h0, ~(8'h01 << d)});
                check($sformatf("scan_seg_k%0d", k), {24'h0, dig_seg}, {24'h0, seg_exp[d]});
                step();
            end
        end

        // Reset in the middle of digit 5 with an LED write in flight.
        dv_addr = 12'h060; dv_wr_data = 32'h00000055; dv_wr_e = 1'b1;
        step();
        dv_wr_e = 1'b0;
        check("pre_rst_led", {8'h0, led}, 32'h55);
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (dig_an == 8'hDF) found = 1;
            else step();
        end
        check("rst_digit5_found", found, 1);
        dv_addr = 12'h060; dv_wr_data = 32'h00FFFFFF; dv_wr_e = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_an", {24'h0, dig_an}, 32'hFF);
        check("midrst_seg", {24'h0, dig_seg}, 32'hFF);
        check("midrst_led", {8'h0, led}, 32'h0);
        step();
        check("midrst_led_held", {8'h0, led}, 32'h0);
        dv_wr_e = 1'b0;
        #2;
        rst_n = 1'b1;
        rd_check("post_rst_disp", 12'h000, 32'h0);
        step();
        check("post_rst_an", {24'h0, dig_an}, 32'hFE);
        check("post_rst_seg", {24'h0, dig_seg}, 32'hC0);
        check("post_rst_led", {8'h0, led}, 32'h0);
        rd_check("post_rst_timer", 12'h020, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
